compute_clock_sequencer: RTL

- Control-clock-domain sequencer that drives the compute clock enable into the clock distribution block's gated compute buffer.
- Runs the compute clock for a programmed number of cycles, or free-runs until stopped.
- Stops the compute clock on behalf of side requesters (memory/cache/exception handlers), settles, then grants exclusive access round-robin.
- Resumes the compute clock when the requester releases, and reports enabled-cycle count and completion to the host controller.

---
 rtl/compute_clock_sequencer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/compute_clock_sequencer.sv
// ---------------------------------------------------------------------------
// compute_clock_sequencer
//
// Control-clock-domain sequencer for the gated compute clock. It runs the
// compute clock for a programmed number of enabled cycles (or free-runs until
// stopped). It stops the clock on behalf of side requesters, lets the domain
// settle, and hands out exclusive access round-robin. When the requester
// releases, it settles again and resumes. It reports the enabled-cycle count
// and a completion pulse to the host.
//
// Ports
//   clock            in   control clock, all logic on posedge
//   reset            in   synchronous, active-high
//   locked           in   clock distribution locked; no enable while low
//   start            in   pulse: begin a run (only honoured when idle)
//   stop             in   pulse: end the current run (ignored when idle)
//   run_length       in   enabled cycles for the run, 0 = free-run
//   req              in   per-requester level request to stop the clock
//   compute_clock_en out  compute buffer enable (high only while running)
//   grant            out  one-hot owner of the stopped compute domain, or 0
//   busy             out  sequencer is not idle
//   done             out  one-cycle run-completion pulse
//   enabled_cycles   out  cycles the enable was high during this run
// ---------------------------------------------------------------------------
module compute_clock_sequencer #(
  parameter int NUM_REQ = 4,
  parameter int COUNT_W = 32,
  parameter int SETTLE  = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               locked,
  input  logic               start,
  input  logic               stop,
  input  logic [COUNT_W-1:0] run_length,
  input  logic [NUM_REQ-1:0] req,
  output logic               compute_clock_en,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] enabled_cycles
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SET_W = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_GRANT,
    ST_RESUME,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic [COUNT_W-1:0] enabled_cycles_q, enabled_cycles_d;
  logic               free_run_q, free_run_d;
  logic               finish_q, finish_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [PTR_W-1:0]   arb_idx;
  logic [PTR_W-1:0]   cand_idx;
  logic [NUM_REQ-1:0] arb_onehot;
  logic               arb_found;
  logic               settle_last;

  // Round-robin pick: scan from the slot just after the last winner and
  // wrap, so the previous owner has lowest priority. The result is only
  // consumed when at least one request is present.
  always_comb begin
    arb_idx    = rr_ptr_q;
    arb_onehot = '0;
    cand_idx   = '0;
    arb_found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_idx = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!arb_found && req[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
    arb_onehot[arb_idx] = 1'b1;
  end

  // Next-state logic for the whole sequencer. The settle counter defaults to
  // zero so every entry into DRAIN or RESUME starts a fresh settle window.
  // The remaining budget is only touched in RUN, so it survives any number
  // of interruptions.
  always_comb begin
    state_d          = state_q;
    remaining_d      = remaining_q;
    enabled_cycles_d = enabled_cycles_q;
    free_run_d       = free_run_q;
    finish_d         = finish_q;
    settle_d         = '0;
    grant_d          = grant_q;
    rr_ptr_d         = rr_ptr_q;
    settle_last      = (settle_q == SET_W'(SETTLE - 1));

    case (state_q)
      ST_IDLE: begin
        if (start && locked) begin
          state_d          = ST_RUN;
          remaining_d      = run_length;
          enabled_cycles_d = '0;
          free_run_d       = (run_length == '0);
          finish_d         = 1'b0;
        end
      end

      // The cycle that triggers the exit is still an enabled cycle and is
      // counted. Ending conditions take priority over a pending request.
      ST_RUN: begin
        enabled_cycles_d = enabled_cycles_q + COUNT_W'(1);
        if (!free_run_q) begin
          remaining_d = remaining_q - COUNT_W'(1);
        end
        if (stop || !locked || (!free_run_q && remaining_q == COUNT_W'(1))) begin
          finish_d = 1'b1;
          state_d  = ST_DRAIN;
        end else if (|req) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (stop) begin
          finish_d = 1'b1;
        end
        if (settle_last) begin
          if (finish_q || stop) begin
            state_d = ST_DONE;
          end else if (|req) begin
            state_d  = ST_GRANT;
            grant_d  = arb_onehot;
            rr_ptr_d = arb_idx;
          end else begin
            state_d = ST_RESUME;
          end
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end

      // While a grant is held, rr_ptr_q names the owner. A zero grant inside
      // this state is the one-cycle gap after a release, where the next
      // step is decided. Stop/unlock only mark the run as finished; the
      // current owner keeps the domain until it lets go.
      ST_GRANT: begin
        if (stop || !locked) begin
          finish_d = 1'b1;
        end
        if (grant_q != '0) begin
          if (!req[rr_ptr_q]) begin
            grant_d = '0;
          end
        end else if (finish_q || stop || !locked) begin
          state_d = ST_DONE;
        end else if (|req) begin
          grant_d  = arb_onehot;
          rr_ptr_d = arb_idx;
        end else begin
          state_d = ST_RESUME;
        end
      end

      ST_RESUME: begin
        if (stop) begin
          finish_d = 1'b1;
        end
        if (settle_last) begin
          if (|req) begin
            state_d  = ST_GRANT;
            grant_d  = arb_onehot;
            rr_ptr_d = arb_idx;
          end else if (!locked || finish_q || stop) begin
            finish_d = 1'b1;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset wins over any activity in
  // the same cycle, so a grant or enable drops at the reset edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      remaining_q      <= '0;
      enabled_cycles_q <= '0;
      free_run_q       <= 1'b0;
      finish_q         <= 1'b0;
      settle_q         <= '0;
      grant_q          <= '0;
      rr_ptr_q         <= PTR_W'(NUM_REQ - 1);
    end else begin
      state_q          <= state_d;
      remaining_q      <= remaining_d;
      enabled_cycles_q <= enabled_cycles_d;
      free_run_q       <= free_run_d;
      finish_q         <= finish_d;
      settle_q         <= settle_d;
      grant_q          <= grant_d;
      rr_ptr_q         <= rr_ptr_d;
    end
  end

  // Outputs come straight from registered state.
  assign compute_clock_en = (state_q == ST_RUN);
  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);
  assign grant            = grant_q;
  assign enabled_cycles   = enabled_cycles_q;

endmodule
